// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch stage.
// Provides word geometry, special instruction encodings, the reset PC and
// the encoding of the next-PC select used by next_pc_mux.
package cpu_defs;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned JIDX_W     = 26;
    localparam int unsigned SEL_W      = 2;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;

    localparam logic [SEL_W-1:0] SEL_SEQ = 2'd0;
    localparam logic [SEL_W-1:0] SEL_BR  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_J   = 2'd2;
    localparam logic [SEL_W-1:0] SEL_JR  = 2'd3;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC resolution.
// Ports:
//   pc, if_id_pc4            current fetch address / pc+4 of the word in ID
//   branch_taken/offset      conditional branch request and word offset
//   jump/jump_index          J-type request and target index
//   jr/jr_target             jump-register request and register value
//   seq_pc_c                 pc + 4 (wraps mod 2^32)
//   sel_c                    prioritised select: jr > jump > branch > seq
//   target_c                 address chosen by sel_c
module next_pc_mux
    import cpu_defs::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   if_id_pc4,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr,
    input  logic [XLEN-1:0]   jr_target,
    output logic [XLEN-1:0]   seq_pc_c,
    output logic [SEL_W-1:0]  sel_c,
    output logic [XLEN-1:0]   target_c
);

    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] j_pc;
    logic [XLEN-1:0] jr_pc;

    // Candidate targets; all sums drop the carry out of bit 31.
    assign seq_pc_c = pc + XLEN'(WORD_BYTES);
    assign br_pc    = if_id_pc4 + (branch_offset << 2);
    assign j_pc     = {if_id_pc4[XLEN-1:XLEN-4], jump_index, 2'b00};
    // Register value is forced to word alignment.
    assign jr_pc    = jr_target & ~XLEN'(WORD_BYTES - 1);

    // Priority select.
    always_comb begin
        sel_c = SEL_SEQ;
        if (jr) begin
            sel_c = SEL_JR;
        end else if (jump) begin
            sel_c = SEL_J;
        end else if (branch_taken) begin
            sel_c = SEL_BR;
        end
    end

    always_comb begin
        target_c = seq_pc_c;
        case (sel_c)
            SEL_BR:  target_c = br_pc;
            SEL_J:   target_c = j_pc;
            SEL_JR:  target_c = jr_pc;
            default: target_c = seq_pc_c;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, halt flag.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall, flush         hold everything / squash IF/ID
//   branch_*, jump*, jr* redirect requests from ID
//   instruction          word read combinationally at address pc
//   pc                   fetch address
//   if_id_instr/pc4      registered instruction and its pc+4
//   if_id_valid          IF/ID holds a real instruction
//   halted               halt word fetched; fetch frozen until reset
module pc_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter logic [31:0] HALT_INSTR = cpu_defs::HALT_INSTR,
    parameter logic [31:0] NOP_INSTR  = cpu_defs::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr,
    input  logic [XLEN-1:0]   jr_target,
    input  logic [XLEN-1:0]   instruction,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_instr,
    output logic [XLEN-1:0]   if_id_pc4,
    output logic              if_id_valid,
    output logic              halted
);

    logic [XLEN-1:0]  seq_pc_c;
    logic [SEL_W-1:0] sel_c;
    logic [XLEN-1:0]  target_c;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc4_d;
    logic            valid_d;
    logic            halted_d;

    next_pc_mux u_next_pc_mux (
        .pc            (pc),
        .if_id_pc4     (if_id_pc4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .seq_pc_c      (seq_pc_c),
        .sel_c         (sel_c),
        .target_c      (target_c)
    );

    // Next-state: halt > stall > redirect > flush > normal fetch.
    always_comb begin
        pc_d     = pc;
        instr_d  = if_id_instr;
        pc4_d    = if_id_pc4;
        valid_d  = if_id_valid;
        halted_d = halted;
        if (halted) begin
            valid_d = 1'b0;
        end else if (stall) begin
            // hold everything; ID re-presents any redirect after the stall
        end else if (sel_c != SEL_SEQ) begin
            // wrong-path word at the old pc is dropped; pc4 left as is
            pc_d    = target_c;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (flush) begin
            pc_d    = seq_pc_c;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = instruction;
            pc4_d   = seq_pc_c;
            valid_d = 1'b1;
            if (instruction == HALT_INSTR) begin
                halted_d = 1'b1;
            end else begin
                pc_d = seq_pc_c;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc          <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc4   <= pc4_d;
            if_id_valid <= valid_d;
            halted      <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Instruction memory returns pc ^ KEY,
// or the halt word at halt_addr when halt_en is set.
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY  = 32'h5A5A_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branch_taken, jump, jr;
    logic [31:0] branch_offset, jr_target, instruction;
    logic [25:0] jump_index;
    logic [31:0] pc, if_id_instr, if_id_pc4;
    logic        if_id_valid, halted;
    logic        halt_en;
    logic [31:0] halt_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign instruction = (halt_en && pc == halt_addr) ? HALT : (pc ^ KEY);

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .instruction   (instruction),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, NOP); end
        total++; if (if_id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc4); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
            total++; if (if_id_pc4 !== exp_pc[i]) begin bad++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, if_id_pc4, exp_pc[i]); end
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, if_id_valid); end
        end
        total++; if (if_id_instr !== 32'h5A5A_0008) begin bad++; $display("FAIL seq_instr got=%h exp=5a5a0008", if_id_instr); end
    endtask

    task automatic test_branch();
        step();  // pc=0x10, pc4=0x10
        total++; if (if_id_pc4 !== 32'h10) begin bad++; $display("FAIL br_pre_pc4 got=%h exp=10", if_id_pc4); end
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0; branch_offset = 32'h0;
        total++; if (pc !== 32'h8) begin bad++; $display("FAIL br_pc got=%h exp=8", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL br_instr got=%h exp=0", if_id_instr); end
        total++; if (if_id_pc4 !== 32'h10) begin bad++; $display("FAIL br_pc4 got=%h exp=10", if_id_pc4); end
        step();
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL br_after_pc got=%h exp=c", pc); end
        total++; if (if_id_instr !== 32'h5A5A_0008) begin bad++; $display("FAIL br_after_instr got=%h exp=5a5a0008", if_id_instr); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL br_after_valid got=%b exp=1", if_id_valid); end
    endtask

    task automatic test_jr_priority();
        jr = 1'b1; jr_target = 32'h103; branch_taken = 1'b1; branch_offset = 32'h40;
        step();
        jr = 1'b0; branch_taken = 1'b0;
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL jr_pc got=%h exp=100", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL jr_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_pc4 !== 32'hC) begin bad++; $display("FAIL jr_pc4 got=%h exp=c", if_id_pc4); end
        step();
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL jr_after_pc got=%h exp=104", pc); end
        total++; if (if_id_instr !== 32'h5A5A_0100) begin bad++; $display("FAIL jr_after_instr got=%h exp=5a5a0100", if_id_instr); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL jr_after_valid got=%b exp=1", if_id_valid); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; jump = 1'b1; jump_index = 26'h200;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc !== 32'h104) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=104", i, pc); end
            total++; if (if_id_pc4 !== 32'h104) begin bad++; $display("FAIL stall_pc4[%0d] got=%h exp=104", i, if_id_pc4); end
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, if_id_valid); end
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
        total++; if (pc !== 32'h800) begin bad++; $display("FAIL jmp_pc got=%h exp=800", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL jmp_valid got=%b exp=0", if_id_valid); end
        step();
        total++; if (pc !== 32'h804) begin bad++; $display("FAIL jmp_after_pc got=%h exp=804", pc); end
        total++; if (if_id_pc4 !== 32'h804) begin bad++; $display("FAIL jmp_after_pc4 got=%h exp=804", if_id_pc4); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (pc !== 32'h808) begin bad++; $display("FAIL fl_pc got=%h exp=808", pc); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL fl_instr got=%h exp=0", if_id_instr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_pc4 !== 32'h804) begin bad++; $display("FAIL fl_pc4 got=%h exp=804", if_id_pc4); end
        step();
        total++; if (if_id_instr !== 32'h5A5A_0808) begin bad++; $display("FAIL fl_after_instr got=%h exp=5a5a0808", if_id_instr); end
    endtask

    task automatic test_halt();
        rst_pulse();
        halt_en = 1'b1; halt_addr = 32'hC;
        // flush on the halt word: not recognised
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_flushed got=%b exp=0", halted); end
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL halt_flushed_pc got=%h exp=10", pc); end
        rst_pulse();
        for (int i = 0; i < 3; i++) step();
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL halt_pre_pc got=%h exp=c", pc); end
        step();
        total++; if (if_id_instr !== HALT) begin bad++; $display("FAIL halt_instr got=%h exp=ffffffff", if_id_instr); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL halt_valid got=%b exp=1", if_id_valid); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL halt_pc got=%h exp=c", pc); end
        jr = 1'b1; jr_target = 32'h400;
        step();
        step();
        jr = 1'b0;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL halt_after_valid got=%b exp=0", if_id_valid); end
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL halt_after_pc got=%h exp=c", pc); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", halted); end
        halt_en = 1'b0;
        rst_pulse();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL halt_rst_pc got=%h exp=0", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_rst_flag got=%b exp=0", halted); end
    endtask

    task automatic test_wrap_async();
        jr = 1'b1; jr_target = 32'hFFFF_FFFF;
        step();
        jr = 1'b0;
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre_pc got=%h exp=fffffffc", pc); end
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        total++; if (if_id_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", if_id_pc4); end
        total++; if (if_id_instr !== 32'hA5A5_FFFC) begin bad++; $display("FAIL wrap_instr got=%h exp=a5a5fffc", if_id_instr); end
        step();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL wrap_next_pc got=%h exp=4", pc); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL async_pc got=%h exp=0", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_pc4 !== 32'h0) begin bad++; $display("FAIL async_pc4 got=%h exp=0", if_id_pc4); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL async_instr got=%h exp=0", if_id_instr); end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_offset = 32'h0;
        jump = 1'b0; jump_index = 26'h0;
        jr = 1'b0; jr_target = 32'h0;
        halt_en = 1'b0; halt_addr = 32'h0;
        step();
        test_reset();
        rst_n = 1'b1;
        test_sequential();
        test_branch();
        test_jr_priority();
        test_stall_redirect();
        test_flush();
        test_halt();
        test_wrap_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
